pong_game_ctrl: RTL

- Game-flow sequencer for the pong datapath: menu, serve countdown, play, point freeze, game over.
- Sits between the top level and the paddle/ball/impact blocks.
- Generates the one-cycle object-reset pulse and the movement enable, and counts frames for timed phases.
- Keeps score (2-digit BCD) and remaining lives for the HUD renderer.

---
 rtl/pong_game_ctrl_if.sv | 28 ++
 rtl/pong_game_ctrl.sv | 134 +++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl_if.sv
// Pong game-flow sequencer bus.
// Groups the event inputs (switch, frame_tick, hit, miss) and the status outputs
// (obj_reset, move_en, state, score digits, lives, game_over).
// The master modport drives the events and observes the status; the slave modport is the
// sequencer side.
interface pong_game_ctrl_if;
  logic       switch;
  logic       frame_tick;
  logic       hit;
  logic       miss;
  logic       obj_reset;
  logic       move_en;
  logic [2:0] state;
  logic [3:0] score_tens;
  logic [3:0] score_ones;
  logic [1:0] lives;
  logic       game_over;

  modport master (
    output switch, frame_tick, hit, miss,
    input  obj_reset, move_en, state, score_tens, score_ones, lives, game_over
  );

  modport slave (
    input  switch, frame_tick, hit, miss,
    output obj_reset, move_en, state, score_tens, score_ones, lives, game_over
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game-flow sequencer: menu, serve countdown, play, point freeze, game over.
// Ports:
//   clock  - pixel-domain clock
//   reset  - synchronous, active-low reset
//   bus    - pong_game_ctrl_if.slave
//            in : switch (async level, 1 = game), frame_tick, hit, miss (1-cycle pulses)
//            out: obj_reset (1-cycle pulse), move_en, state[2:0], score_tens/ones (BCD),
//                 lives[1:0], game_over
module pong_game_ctrl #(
  parameter int unsigned LIVES        = 3,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 90
) (
  input logic            clock,
  input logic            reset,
  pong_game_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    StMenu     = 3'd0,
    StServe    = 3'd1,
    StPlay     = 3'd2,
    StPoint    = 3'd3,
    StGameOver = 3'd4
  } state_e;

  localparam logic [7:0] ServeLast = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] PointLast = 8'(POINT_FRAMES - 1);
  localparam logic [1:0] LivesInit = 2'(LIVES);

  logic       sw_meta_q, sw_s_q;
  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic [1:0] lives_q, lives_d;
  logic       obj_reset_q, obj_reset_d;
  // Set while in reset so the first cycle after release emits an obj_reset pulse.
  logic       init_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sw_meta_q   <= 1'b0;
      sw_s_q      <= 1'b0;
      state_q     <= StMenu;
      cnt_q       <= '0;
      tens_q      <= '0;
      ones_q      <= '0;
      lives_q     <= LivesInit;
      obj_reset_q <= 1'b0;
      init_q      <= 1'b1;
    end else begin
      sw_meta_q   <= bus.switch;
      sw_s_q      <= sw_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      lives_q     <= lives_d;
      obj_reset_q <= obj_reset_d;
      init_q      <= 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    lives_d = lives_q;

    if (!sw_s_q) begin
      // Abort: score and lives are kept for display in the menu.
      state_d = StMenu;
    end else begin
      case (state_q)
        StMenu: begin
          state_d = StServe;
          tens_d  = '0;
          ones_d  = '0;
          lives_d = LivesInit;
        end
        StServe: begin
          if (bus.frame_tick) begin
            if (cnt_q == ServeLast) state_d = StPlay;
            else                    cnt_d   = cnt_q + 8'd1;
          end
        end
        StPlay: begin
          if (bus.miss) begin
            if (lives_q <= 2'd1) begin
              lives_d = '0;
              state_d = StGameOver;
            end else begin
              lives_d = lives_q - 2'd1;
              state_d = StPoint;
            end
          end else if (bus.hit) begin
            // BCD increment, saturating at 99.
            if (ones_q == 4'd9) begin
              if (tens_q != 4'd9) begin
                ones_d = '0;
                tens_d = tens_q + 4'd1;
              end
            end else begin
              ones_d = ones_q + 4'd1;
            end
          end
        end
        StPoint: begin
          if (bus.frame_tick) begin
            if (cnt_q == PointLast) state_d = StServe;
            else                    cnt_d   = cnt_q + 8'd1;
          end
        end
        StGameOver: ;
        default: state_d = StMenu;
      endcase
    end

    if (state_d != state_q) cnt_d = '0;

    obj_reset_d = init_q | ((state_d == StServe) && (state_q != StServe));
  end

  assign bus.obj_reset  = obj_reset_q;
  assign bus.move_en    = (state_q == StPlay);
  assign bus.game_over  = (state_q == StGameOver);
  assign bus.state      = state_q;
  assign bus.score_tens = tens_q;
  assign bus.score_ones = ones_q;
  assign bus.lives      = lives_q;

endmodule
